ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit in the EX stage. It consumes the operand and control fields that the ID/EX pipeline register presents and produces a 64-bit HI/LO result. While an operation is in flight it holds the pipeline through a stall output to the hazard logic. It is the reading end of the ID/EX interface for MULT/MULTU/DIV/DIVU instructions.

## Interface
Parameters:
- none; iteration count fixed at 32 (package constant).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  ID/EX EX-field decode: current EX instruction is a mul/div op (level, may stay high while stalled).
- op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled only on accepted start.
- data1_i  in  32  rs operand from ID/EX (multiplicand / dividend).
- data2_i  in  32  rt operand from ID/EX (multiplier / divisor).
- stall_o  out  1  freeze PC, IF/ID, ID/EX.
- done_o  out  1  one-cycle completion pulse.
- hi_o  out  32  product[63:32] / remainder.
- lo_o  out  32  product[31:0] / quotient.

One clock (clk_i); reset (rst_i) is synchronous and active-high.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start_i=1 → capture op_i and operand magnitudes, clear counter, go to CALC.
  - Signed ops take magnitudes and record signs s1=data1_i[31], s2=data2_i[31].
- CALC: one radix-2 step per cycle, counter 0..31.
  - Multiply: shift-add into 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient in low half, remainder in high half.
  - Counter 31 → FIX.
- FIX: signed ops only alter data.
  - MULT: negate 64-bit product if s1^s2.
  - DIV: negate quotient if s1^s2; negate remainder if s1.
  - Unsigned ops pass through.
  - Always → DONE.
- DONE:
  - hi_o/lo_o already updated by the FIX→DONE edge.
  - done_o=1; start_i ignored this cycle.
  - Always → IDLE.
- hi_o/lo_o hold their value until the next completion. They are updated only by the FIX→DONE edge.
- stall_o = (IDLE & start_i) | CALC | FIX. It is low in DONE, so the mul/div instruction leaves EX at the end of the DONE cycle.
- Divide by zero: completes normally, no exception; lo_o=0xFFFFFFFF, hi_o=dividend as supplied (signed and unsigned).
- DIV 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0 (magnitude arithmetic wraps naturally).
- op_i/data changes after acceptance: ignored.
- Reset in any state: state IDLE, counter 0, hi_o=lo_o=0, done_o=0, stall_o=0 in the following cycle. No partial result is written.

## Timing
- Reset values: stall_o=0, done_o=0, hi_o=0, lo_o=0, state IDLE.
- Cycle 0: start accepted, stall_o=1 (combinational from start_i).
- Cycles 1–32: CALC, stall_o=1.
- Cycle 33: FIX, stall_o=1.
- Cycle 34: DONE, done_o=1, hi_o/lo_o valid, stall_o=0.
- Latency start→done is 34 cycles. Back-to-back ops: next start is accepted at cycle 35 at the earliest.
- start_i held high continuously restarts at cycle 35. This is correct, since ID/EX presents the next instruction after the DONE edge.

## Configuration
- MULDIV_SIGNED_EN defined: op_i[0]=1 selects signed MULT/DIV as above.
- Not defined: op_i[0] ignored; all ops are unsigned, and FIX passes data through unchanged (state still traversed, latency unchanged).

## Structure
- Package muldiv_pkg:
  - op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - state enum;
  - MULDIV_ITER=32;
  - divide-by-zero quotient constant 0xFFFFFFFF.
- Sub-module muldiv_step: combinational single radix-2 step (mode, 64-bit accumulator, 32-bit operand → next accumulator). Instanced once in ex_muldiv.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → done_o at cycle 34; hi_o=0xFFFFFFFE, lo_o=0x00000001; stall_o high cycles 0–33 only.
- MULT −3×5 (0xFFFFFFFD, 0x00000005), signed enabled → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1. Same stimulus without the macro → hi_o=0x00000004, lo_o=0xFFFFFFF1.
- DIV −7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 → lo_o=14, hi_o=2.
- DIVU 100/0 → lo_o=0xFFFFFFFF, hi_o=0x00000064, done_o pulses normally.
- rst_i high at cycle 10 of an op → cycle 11: stall_o=0, hi_o=lo_o=0; no done_o pulse afterwards with start_i low.
- start_i held high across two ops with new operands presented at cycle 35 → two done_o pulses at cycles 34 and 69, each with correct result; no extra acceptance during DONE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the EX-stage iterative multiply/divide unit.
// Op encodings, FSM state codes, iteration count and divide-by-zero quotient.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_CALC = 2'd1;
    localparam state_t S_FIX  = 2'd2;
    localparam state_t S_DONE = 2'd3;

    localparam int          MULDIV_ITER = 32;
    localparam logic [31:0] DIV0_QUOT   = 32'hFFFF_FFFF;

    // Two's-complement magnitude when neg is set, pass-through otherwise.
    function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 step: shift-add multiply or restoring shift-subtract divide
// on a 64-bit {hi, lo} accumulator.
module muldiv_step (
    input  logic        div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] opnd_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] rem;
    logic [31:0] diff;

    // Remainder is 33 bits after the shift; when it is >= the divisor the
    // difference always fits in 32 bits, so a 32-bit subtract is exact.
    always_comb begin
        sum  = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
        rem  = acc_i[63:31];
        diff = rem[31:0] - opnd_i;
        if (div_i) begin
            if (rem >= {1'b0, opnd_i}) begin
                acc_o = {diff, acc_i[30:0], 1'b1};
            end else begin
                acc_o = {rem[31:0], acc_i[30:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[31:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit, 34-cycle latency, stalls ID/EX.
// Signed ops are available only when MULDIV_SIGNED_EN is defined.
module ex_muldiv
    import muldiv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

`ifdef MULDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        div_q, div_d;
    logic        sgn_q, sgn_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        in_sgn;
    logic [31:0] mag1, mag2;
    logic [63:0] step_acc;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign in_sgn = SIGNED_EN & op_i[0];
    assign mag1   = mag(data1_i, in_sgn & data1_i[31]);
    assign mag2   = mag(data2_i, in_sgn & data2_i[31]);

    muldiv_step u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (step_acc)
    );

    // Sign correction; a zero divisor keeps the all-ones quotient, and the
    // remainder negation restores the dividend as supplied.
    always_comb begin
        prod_fix = (sgn_q & (s1_q ^ s2_q)) ? (~acc_q + 64'd1) : acc_q;
        rem_fix  = (sgn_q & s1_q) ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        if (dz_q) begin
            quo_fix = DIV0_QUOT;
        end else if (sgn_q & (s1_q ^ s2_q)) begin
            quo_fix = ~acc_q[31:0] + 32'd1;
        end else begin
            quo_fix = acc_q[31:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CALC;
                    cnt_d   = 5'd0;
                    div_d   = op_i[1];
                    sgn_d   = in_sgn;
                    s1_d    = in_sgn & data1_i[31];
                    s2_d    = in_sgn & data2_i[31];
                    dz_d    = (data2_i == 32'd0);
                    opnd_d  = op_i[1] ? mag2 : mag1;
                    acc_d   = {32'd0, (op_i[1] ? mag1 : mag2)};
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(MULDIV_ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign stall_o = ((state_q == S_IDLE) & start_i) | (state_q == S_CALC) | (state_q == S_FIX);
    assign done_o  = (state_q == S_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases, reset abort,
// back-to-back ops and random ops against an arithmetic reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst_i, start_i;
    logic [1:0]  op_i;
    logic [31:0] data1_i, data2_i;
    logic        stall_o, done_o;
    logic [31:0] hi_o, lo_o;

    int nCmp  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .stall_o (stall_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit     sg;
        longint sa, sb, q, r;
`ifdef MULDIV_SIGNED_EN
        sg = op[0];
`else
        sg = 1'b0;
`endif
        sa = $signed(a);
        sb = $signed(b);
        if (!op[1]) begin
            if (sg) return 64'(sa * sb);
            return {32'd0, a} * {32'd0, b};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sg) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        op_i    = op;
        data1_i = a;
        data2_i = b;
    endtask

    // Cycles until done_o relative to the current cycle; -1 if it never comes.
    task automatic waitDone(input bit dropStart, output int rel, output bit stallOk);
        rel     = -1;
        stallOk = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && dropStart) start_i = 1'b0;
            if (done_o === 1'b1) begin
                rel = k;
                break;
            end
            if (stall_o !== 1'b1) stallOk = 1'b0;
        end
    endtask

    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          rel;
        bit          ok;
        exp = refResult(op, a, b);
        applyStimulus(op, a, b);
        #1;
        checkOutput({tag, " stall@0"}, 64'(stall_o), 64'd1);
        waitDone(1'b1, rel, ok);
        checkOutput({tag, " latency"}, 64'(rel), 64'd34);
        checkOutput({tag, " stall 1..33"}, 64'(ok), 64'd1);
        checkOutput({tag, " stall@done"}, 64'(stall_o), 64'd0);
        checkOutput({tag, " result"}, {hi_o, lo_o}, exp);
        @(posedge clk);
        #1;
        checkOutput({tag, " done pulse"}, 64'(done_o), 64'd0);
        checkOutput({tag, " hold"}, {hi_o, lo_o}, exp);
    endtask

    initial begin
        logic [63:0] exp;
        int          rel, doneCnt;
        bit          ok, stallSeen;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; data1_i = '0; data2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset state", {30'd0, stall_o, done_o, hi_o, lo_o}, 64'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        runOp("MULTU max",  2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checkOutput("MULTU max const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        runOp("MULT -3*5",  2'b01, 32'hFFFF_FFFD, 32'h0000_0005);
        runOp("DIV -7/2",   2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
        runOp("DIVU 100/7", 2'b10, 32'd100, 32'd7);
        checkOutput("DIVU 100/7 const", {hi_o, lo_o}, {32'd2, 32'd14});
        runOp("DIV ovf",    2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp("DIV -7/0",   2'b11, 32'hFFFF_FFF9, 32'd0);
        runOp("DIVU 100/0", 2'b10, 32'd100, 32'd0);
        checkOutput("DIVU 100/0 const", {hi_o, lo_o}, {32'h0000_0064, 32'hFFFF_FFFF});

        // Reset asserted in cycle 10 of an op aborts it with no result.
        applyStimulus(2'b00, 32'd1234, 32'd5678);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start_i = 1'b0;
        end
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst abort", {30'd0, stall_o, done_o, hi_o, lo_o}, 64'd0);
        rst_i = 1'b0;
        doneCnt = 0;
        stallSeen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_o === 1'b1) doneCnt++;
            if (stall_o === 1'b1) stallSeen = 1'b1;
        end
        checkOutput("rst no done", 64'(doneCnt), 64'd0);
        checkOutput("rst no stall", 64'(stallSeen), 64'd0);

        // start_i held high across two ops; second is accepted at cycle 35.
        exp = refResult(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        applyStimulus(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        waitDone(1'b0, rel, ok);
        checkOutput("b2b #1 latency", 64'(rel), 64'd34);
        checkOutput("b2b #1 result", {hi_o, lo_o}, exp);
        @(posedge clk);
        #1;
        applyStimulus(2'b10, 32'hDEAD_BEEF, 32'd12345);
        #1;
        checkOutput("b2b accept@35", {62'd0, stall_o, done_o}, 64'd2);
        exp = refResult(2'b10, 32'hDEAD_BEEF, 32'd12345);
        waitDone(1'b0, rel, ok);
        checkOutput("b2b #2 latency", 64'(rel), 64'd34);
        checkOutput("b2b #2 stall", 64'(ok), 64'd1);
        checkOutput("b2b #2 result", {hi_o, lo_o}, exp);
        start_i = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (rop[1] && (i % 2 == 1)) rb = $urandom_range(1, 255);
            if (i % 5 == 4) rb = 32'd0;
            runOp($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
